test_status_monitor: RTL and testbench

TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

---
 rtl/test_status_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_test_status_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_status_monitor.sv
// -----------------------------------------------------------------------------
// test_status_monitor
//
// Watches the register-file write-back port of a core running a self-checking
// test program and turns the program's conventions into a verdict:
//   - a write of 1 to END_REG marks the end of the test,
//   - the value held in PASS_REG at that point (after a short settle window)
//     decides pass or fail,
//   - TNUM_REG carries the number of the sub-test currently running,
//   - a run that never writes END_REG within TIMEOUT_CYC cycles times out.
//
// Parameters
//   END_REG      register index whose write of 1 marks test end
//   PASS_REG     register index whose value 1 marks pass
//   TNUM_REG     register index holding the current test number
//   TIMEOUT_CYC  run cycles allowed before timeout (1 .. 2^CNT_W-1)
//   SETTLE_CYC   cycles waited after end before the verdict (0 .. 255)
//   CNT_W        width of the run-cycle counter
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   en          run enable; counting and snooping happen only while high
//   clr         synchronous restart to the RUN start condition
//   wb_en       register-file write strobe
//   wb_addr     register-file write index
//   wb_data     register-file write data
//   busy        high in RUN or SETTLE
//   done        sticky, high in any terminal state
//   done_pulse  one-cycle pulse on entry to a terminal state
//   pass        sticky verdict: passed
//   fail        sticky verdict: failed
//   timeout     sticky verdict: timed out
//   test_num    last value written to TNUM_REG
//   cycles      run-cycle count (saturating, frozen once done)
// -----------------------------------------------------------------------------
module test_status_monitor #(
    parameter int          END_REG     = 26,
    parameter int          PASS_REG    = 27,
    parameter int          TNUM_REG    = 3,
    parameter int unsigned TIMEOUT_CYC = 2000,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    output logic             busy,
    output logic             done,
    output logic             done_pulse,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [31:0]      test_num,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SETTLE,
        ST_PASS,
        ST_FAIL,
        ST_TOUT
    } state_t;

    localparam logic [4:0]       END_IDX   = 5'(END_REG);
    localparam logic [4:0]       PASS_IDX  = 5'(PASS_REG);
    localparam logic [4:0]       TNUM_IDX  = 5'(TNUM_REG);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [7:0]       SETTLE_V  = 8'(SETTLE_CYC);

    function automatic logic is_term(input state_t s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TOUT);
    endfunction

    state_t            state_q;
    state_t            state_d;
    logic [7:0]        settle_q;
    logic [7:0]        settle_d;
    logic [CNT_W-1:0]  cycles_d;
    logic [CNT_W-1:0]  cycles_inc;
    logic [31:0]       pass_sh_q;
    logic [31:0]       pass_sh_d;
    logic [31:0]       end_sh_q;
    logic [31:0]       end_sh_d;
    logic [31:0]       tnum_d;

    logic   wr_ok;
    logic   pass_wr;
    logic   end_wr;
    logic   tnum_wr;
    logic   end_hit;
    state_t verdict;

    // A write is snooped only while running; index 0 is the hard-wired zero
    // register, so a write to it carries no information.
    assign wr_ok   = wb_en && en && (wb_addr != 5'd0);
    assign pass_wr = wr_ok && (wb_addr == PASS_IDX);
    assign end_wr  = wr_ok && (wb_addr == END_IDX);
    assign tnum_wr = wr_ok && (wb_addr == TNUM_IDX);

    // Shadow values as they will be after this edge. The verdict uses the
    // forwarded pass value so a pass write landing on the last settle cycle
    // still counts.
    assign pass_sh_d = pass_wr ? wb_data : pass_sh_q;
    assign end_sh_d  = end_wr  ? wb_data : end_sh_q;
    assign tnum_d    = tnum_wr ? wb_data : test_num;

    // The end shadow can only hold 1 outside RUN (reaching 1 leaves RUN on
    // the same edge), so in RUN this is exactly "a write of 1 to END_REG now".
    assign end_hit = (end_sh_d == 32'h1);
    assign verdict = (pass_sh_d == 32'h1) ? ST_PASS : ST_FAIL;

    assign cycles_inc = (&cycles) ? cycles : cycles + CNT_W'(1);

    // NOTE: every signal assigned here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        cycles_d = cycles;
        if (en) begin
            case (state_q)
                ST_RUN: begin
                    cycles_d = cycles_inc;
                    // End wins over a timeout expiring on the same cycle.
                    if (end_hit) begin
                        if (SETTLE_V == 8'd0) begin
                            state_d = verdict;
                        end else begin
                            state_d  = ST_SETTLE;
                            settle_d = SETTLE_V;
                        end
                    end else if (cycles_inc == TIMEOUT_V) begin
                        state_d = ST_TOUT;
                    end
                end
                ST_SETTLE: begin
                    cycles_d = cycles_inc;
                    if (settle_q <= 8'd1) begin
                        state_d = verdict;
                    end else begin
                        settle_d = settle_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the values from before this edge regardless of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            settle_q   <= 8'd0;
            cycles     <= '0;
            pass_sh_q  <= 32'h0;
            end_sh_q   <= 32'h0;
            test_num   <= 32'h0;
            busy       <= 1'b1;
            done       <= 1'b0;
            done_pulse <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
        end else if (clr) begin
            // Restart overrides run enable and any write on this cycle.
            state_q    <= ST_RUN;
            settle_q   <= 8'd0;
            cycles     <= '0;
            pass_sh_q  <= 32'h0;
            end_sh_q   <= 32'h0;
            test_num   <= 32'h0;
            busy       <= 1'b1;
            done       <= 1'b0;
            done_pulse <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            cycles     <= cycles_d;
            pass_sh_q  <= pass_sh_d;
            end_sh_q   <= end_sh_d;
            test_num   <= tnum_d;
            // Status flags are registered from the next state so they line
            // up with the state register and never glitch.
            busy       <= (state_d == ST_RUN) || (state_d == ST_SETTLE);
            done       <= is_term(state_d);
            done_pulse <= is_term(state_d) && !is_term(state_q);
            pass       <= (state_d == ST_PASS);
            fail       <= (state_d == ST_FAIL);
            timeout    <= (state_d == ST_TOUT);
        end
    end

endmodule

// File: tb/tb_test_status_monitor.sv
// -----------------------------------------------------------------------------
// tb_test_status_monitor
//
// Two monitors share one stimulus stream: one with a 2-cycle settle window and
// one with no settle window, both with a 100-cycle timeout. For every test the
// stimulus plan is handed to a reference model that works in "enabled cycles"
// (count them, remember the last value written to each register of interest,
// find the end write) and the predicted verdict is queued per monitor. Two
// monitor processes pop and compare whenever a monitor raises done_pulse.
// -----------------------------------------------------------------------------
module tb_test_status_monitor;

    localparam int TOUT     = 100;
    localparam int PLAN_MAX = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_data = 32'd0;

    logic        busy2, done2, dp2, pass2, fail2, tout2;
    logic [31:0] tnum2, cyc2;
    logic        busy0, done0, dp0, pass0, fail0, tout0;
    logic [31:0] tnum0, cyc0;

    always #5 clk = ~clk;

    test_status_monitor #(.TIMEOUT_CYC(TOUT), .SETTLE_CYC(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy2), .done(done2), .done_pulse(dp2),
        .pass(pass2), .fail(fail2), .timeout(tout2),
        .test_num(tnum2), .cycles(cyc2)
    );

    test_status_monitor #(.TIMEOUT_CYC(TOUT), .SETTLE_CYC(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy0), .done(done0), .done_pulse(dp0),
        .pass(pass0), .fail(fail0), .timeout(tout0),
        .test_num(tnum0), .cycles(cyc0)
    );

    typedef struct {
        bit          en;
        bit          we;
        logic [4:0]  a;
        logic [31:0] d;
    } cyc_t;

    typedef struct {
        logic [2:0]  flags;     // {pass, fail, timeout}
        logic [31:0] tnum;
        int          cycles;
        int          pulse_at;  // plan index during which done_pulse is seen
    } exp_t;

    cyc_t plan [PLAN_MAX];
    int   plan_len;
    exp_t q2[$];
    exp_t q0[$];
    exp_t last2, last0;
    int   cur_idx = -1;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the enabled cycles, end is the first write of exactly 1
    // to x26 before the timeout count is reached; the verdict lands `settle`
    // enabled cycles later with whatever x27 holds by then.
    function automatic exp_t model(input int settle);
        exp_t        e;
        cyc_t        c;
        int          n;
        int          end_n;
        bit          found;
        logic [31:0] pv, tv;
        n = 0; end_n = -1; found = 1'b0; pv = 32'd0; tv = 32'd0;
        e.flags = 3'b000; e.tnum = 32'd0; e.cycles = 0; e.pulse_at = -1;
        for (int i = 0; i < plan_len + TOUT + 8 && !found; i++) begin
            if (i < plan_len) c = plan[i];
            else              c = '{1'b1, 1'b0, 5'd0, 32'd0};
            if (c.en) begin
                n++;
                if (c.we && c.a != 5'd0) begin
                    if (c.a == 5'd27) pv = c.d;
                    if (c.a == 5'd3)  tv = c.d;
                    if (c.a == 5'd26 && c.d == 32'd1 && end_n < 0) end_n = n;
                end
                if ((end_n >= 0 && n == end_n + settle) || (end_n < 0 && n == TOUT)) begin
                    found      = 1'b1;
                    e.flags    = (end_n < 0) ? 3'b001 : ((pv == 32'd1) ? 3'b100 : 3'b010);
                    e.cycles   = n;
                    e.tnum     = tv;
                    e.pulse_at = i + 1;
                end
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin : mon2
        exp_t e;
        if (dp2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("s2 done_pulse with no verdict pending", 64'(dp2), 64'd0);
            end else begin
                e = q2.pop_front();
                check("s2 verdict {pass,fail,timeout}", {pass2, fail2, tout2}, e.flags);
                check("s2 test_num", tnum2, e.tnum);
                check("s2 cycles", cyc2, 64'(e.cycles));
                check("s2 {busy,done}", {busy2, done2}, 2'b01);
                check("s2 done_pulse cycle", 64'(cur_idx), 64'(e.pulse_at));
            end
        end
    end

    always @(negedge clk) begin : mon0
        exp_t e;
        if (dp0 === 1'b1) begin
            if (q0.size() == 0) begin
                check("s0 done_pulse with no verdict pending", 64'(dp0), 64'd0);
            end else begin
                e = q0.pop_front();
                check("s0 verdict {pass,fail,timeout}", {pass0, fail0, tout0}, e.flags);
                check("s0 test_num", tnum0, e.tnum);
                check("s0 cycles", cyc0, 64'(e.cycles));
                check("s0 {busy,done}", {busy0, done0}, 2'b01);
                check("s0 done_pulse cycle", 64'(cur_idx), 64'(e.pulse_at));
            end
        end
    end

    task automatic drive(input cyc_t c);
        en      = c.en;
        wb_en   = c.we;
        wb_addr = c.a;
        wb_data = c.d;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " s2 {busy,done,pulse,pass,fail,timeout}"},
              {busy2, done2, dp2, pass2, fail2, tout2}, 6'b100000);
        check({tag, " s2 {test_num,cycles}"}, {tnum2, cyc2}, 64'd0);
        check({tag, " s0 {busy,done,pulse,pass,fail,timeout}"},
              {busy0, done0, dp0, pass0, fail0, tout0}, 6'b100000);
        check({tag, " s0 {test_num,cycles}"}, {tnum0, cyc0}, 64'd0);
    endtask

    // clr asserted together with an end write (and random en): clr must win.
    task automatic do_clear;
        @(posedge clk); #1;
        clr = 1'b1;
        drive('{1'($urandom_range(0, 1)), 1'b1, 5'd26, 32'd1});
        @(posedge clk); #1;
        clr = 1'b0;
        drive('{1'b0, 1'b0, 5'd0, 32'd0});
        check_reset_state("after clr");
    endtask

    task automatic blank(input int len);
        plan_len = len;
        for (int i = 0; i < len; i++) plan[i] = '{1'b1, 1'b0, 5'd0, 32'd0};
    endtask

    task automatic put(input int i, input logic [4:0] a, input logic [31:0] d);
        plan[i].we = 1'b1;
        plan[i].a  = a;
        plan[i].d  = d;
    endtask

    task automatic gen_random;
        plan_len = $urandom_range(20, 90);
        for (int i = 0; i < plan_len; i++) begin
            int sel;
            plan[i].en = ($urandom_range(0, 9) != 0);
            plan[i].we = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: begin plan[i].a = 5'd3; plan[i].d = $urandom; end
                3, 4, 5: begin
                    plan[i].a = 5'd27;
                    plan[i].d = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 1));
                end
                6, 7: begin
                    plan[i].a = 5'd26;
                    plan[i].d = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'($urandom_range(2, 9));
                end
                8:       begin plan[i].a = 5'd0; plan[i].d = 32'd1; end
                default: begin plan[i].a = 5'($urandom); plan[i].d = $urandom; end
            endcase
        end
    endtask

    // Issue the plan (then idle enabled cycles) until both verdicts have been
    // seen, or only up to stop_at when stop_at >= 0.
    task automatic run_plan(input bit push2, input int stop_at);
        exp_t e2, e0;
        cyc_t c;
        int   en_cnt;
        en_cnt = 0;
        e2 = model(2);
        e0 = model(0);
        if (push2) q2.push_back(e2);
        q0.push_back(e0);
        last2 = e2;
        last0 = e0;
        for (int i = 0; ; i++) begin
            if (stop_at >= 0 && i == stop_at) break;
            if (stop_at < 0 && i >= plan_len && q2.size() == 0 && q0.size() == 0) break;
            if (i > plan_len + 3 * TOUT) begin
                check("verdicts still pending at cycle budget", 64'(q2.size() + q0.size()), 64'd0);
                q2.delete();
                q0.delete();
                break;
            end
            @(posedge clk); #1;
            if (i < plan_len) c = plan[i];
            else              c = '{1'b1, 1'b0, 5'd0, 32'd0};
            drive(c);
            cur_idx = i;
            if (!c.en) begin
                check("s2 cycles while en=0", cyc2, 64'((en_cnt < e2.cycles) ? en_cnt : e2.cycles));
                check("s0 cycles while en=0", cyc0, 64'((en_cnt < e0.cycles) ? en_cnt : e0.cycles));
            end
            if (c.en) en_cnt++;
        end
    endtask

    task automatic check_sticky;
        repeat (3) begin
            @(posedge clk); #1;
            drive('{1'b1, 1'b0, 5'd0, 32'd0});
        end
        check("s2 sticky {busy,done,pass,fail,timeout}", {busy2, done2, pass2, fail2, tout2}, {2'b01, last2.flags});
        check("s2 cycles frozen", cyc2, 64'(last2.cycles));
        check("s0 sticky {busy,done,pass,fail,timeout}", {busy0, done0, pass0, fail0, tout0}, {2'b01, last0.flags});
        check("s0 cycles frozen", cyc0, 64'(last0.cycles));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_state("power-on reset");
        rst = 1'b1;

        // Pass: x3=5, x27=1, x26=1 on cycle 40.
        do_clear;
        blank(80); put(5, 5'd3, 32'd5); put(10, 5'd27, 32'd1); put(39, 5'd26, 32'd1);
        run_plan(1'b1, -1); check_sticky;

        // Fail: x3=7, x27=0, x26=1 (also a clr after PASS).
        do_clear;
        blank(30); put(3, 5'd3, 32'd7); put(6, 5'd27, 32'd0); put(12, 5'd26, 32'd1);
        run_plan(1'b1, -1); check_sticky;

        // Late pass: x27=1 one cycle after the end write.
        do_clear;
        blank(30); put(2, 5'd3, 32'd9); put(10, 5'd26, 32'd1); put(11, 5'd27, 32'd1);
        run_plan(1'b1, -1); check_sticky;

        // Timeout with no writes.
        do_clear;
        plan_len = 0;
        run_plan(1'b1, -1); check_sticky;

        // End write on the expiry cycle wins over timeout.
        do_clear;
        blank(110); put(50, 5'd27, 32'd1); put(99, 5'd26, 32'd1);
        run_plan(1'b1, -1); check_sticky;

        // Ignored writes: x26=2, index 0, and writes while en=0.
        do_clear;
        blank(50); put(3, 5'd26, 32'd2); put(5, 5'd0, 32'd1);
        for (int i = 8; i < 18; i++) begin
            plan[i].en = 1'b0;
            put(i, 5'd26, 32'd1);
        end
        put(20, 5'd3, 32'd4); put(25, 5'd27, 32'd1); put(30, 5'd26, 32'd1);
        run_plan(1'b1, -1); check_sticky;

        // Asynchronous reset while the settle-2 monitor sits in SETTLE.
        do_clear;
        blank(12); put(2, 5'd3, 32'd6); put(4, 5'd27, 32'd1); put(8, 5'd26, 32'd1);
        run_plan(1'b0, 10);
        @(negedge clk); #2;
        check("s2 {busy,done} in SETTLE before reset", {busy2, done2}, 2'b10);
        rst = 1'b0;
        #1;
        check_reset_state("async reset mid-SETTLE");
        check("verdicts pending at reset", 64'(q0.size()), 64'd0);
        drive('{1'b1, 1'b1, 5'd26, 32'd1});
        @(posedge clk); @(posedge clk); #1;
        check_reset_state("held in reset");
        @(negedge clk);
        drive('{1'b0, 1'b0, 5'd0, 32'd0});
        rst = 1'b1;
        blank(40); put(1, 5'd3, 32'd11); put(5, 5'd27, 32'd1); put(20, 5'd26, 32'd1);
        run_plan(1'b1, -1); check_sticky;

        // Randomized runs.
        for (int t = 0; t < 24; t++) begin
            do_clear;
            gen_random;
            run_plan(1'b1, -1);
            check_sticky;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
